mux_nx1_varredura: RTL
======================

// Module: mux_nx1_varredura
// PURPOSE
//   Parametrised, registered N-to-1 channel selector of W-bit words for the Memory Challenge datapath.
//   Two modes: manual, where the FSM loads a channel index, and scan, where channels advance
//   automatically on a prescaled tick. Used for display time-multiplexing and sequence playback.
//   Replaces the combinational 1-bit 2x1 selector wherever a registered, multi-channel path is needed.
// PARAMETERS
//   N         4      number of input channels (>=2)
//   W         4      bits per channel
//   PRESCALE  50000  clock cycles per scan step (>=1)
//   SEL_W     $clog2(N)  width of channel index (derived, not to be overridden)
// PORTS
//   clock          in   1        system clock, all logic on rising edge
//   reset          in   1        synchronous, active-high
//   dados          in   N*W      packed inputs; channel k = dados[k*W +: W]
//   sel            in   SEL_W    channel index for manual load
//   carrega_sel    in   1        manual mode: latch sel this cycle
//   modo           in   1        0 = manual, 1 = scan
//   habilita       in   1        scan mode: prescaler counts only while high
//   saida          out  W        registered selected word
//   canal          out  SEL_W    current channel index
//   valido         out  1        high when saida holds a legal channel's data
//   fim_varredura  out  1        1-cycle pulse when scan wraps N-1 -> 0
// BEHAVIOUR
//   - Reset (sync): saida=0, canal=0, valido=0, fim_varredura=0, prescaler=0, previous-mode reg=0.
//     Reset wins over every other input in the same cycle; mid-scan reset restarts at channel 0.
//   - Output path: saida <= word[canal] every cycle; latency is 1 clock from canal/dados change.
//     If canal >= N (possible only when N is not a power of 2): saida <= all ones, valido <= 0.
//     Otherwise valido <= 1.
//   - Manual (modo=0): carrega_sel=1 -> canal <= sel at the next edge; saida reflects it one edge later.
//     sel >= N is still loaded; output is then all ones with valido=0 (no clamping).
//     Prescaler is held at 0; fim_varredura stays 0.
//   - Scan (modo=1): while habilita=1, prescaler counts 0..PRESCALE-1. At PRESCALE-1 it returns to 0 and
//     canal advances: canal <= (canal==N-1) ? 0 : canal+1. In the same cycle, fim_varredura=1 iff canal==N-1.
//     If habilita=0, prescaler and canal freeze; there is no reset of the count.
//     carrega_sel is ignored in scan mode. If canal >= N on a tick, the next value is 0.
//   - Mode change 0->1 (detected against the registered previous mode): canal <= 0 and prescaler <= 0
//     in that cycle. No tick fires in that cycle.
//     Mode change 1->0: canal keeps its value, prescaler <= 0. A simultaneous carrega_sel applies.
//   - PRESCALE=1: the tick fires on every enabled cycle.
//   - fim_varredura is registered and asserted for exactly one cycle per wrap.
// STRUCTURE
//   - Shared package (jogo_pkg): MODO_MANUAL=1'b0 and MODO_VARREDURA=1'b1 constants.
//   - One sub-module: contador_m (modulo-M counter with enable, sync clear, terminal-count flag).
//     It is instantiated with M=PRESCALE as the prescaler.
//   - The channel register, mode-edge detect and output register are inline; there is no FSM beyond these.
// TESTING
//   1. Reset: assert reset for 2 cycles with dados=16'hABCD, modo=1.
//      -> saida=0, canal=0, valido=0, fim_varredura=0.
//   2. Manual: N=4, W=4, dados=16'h4321, sel=2, carrega_sel pulse.
//      -> canal=2 after 1 edge; saida=4'h3, valido=1 after 2 edges.
//   3. Scan: PRESCALE=3, habilita=1, modo 0->1.
//      -> canal steps 0,1,2,3,0 every 3 cycles; fim_varredura pulses once on the 3->0 step.
//   4. Freeze and ignore: in scan mode, drop habilita for 10 cycles.
//      -> canal and prescaler hold. carrega_sel with sel=1 during scan -> canal unchanged.
//   5. Out of range: N=3, sel=3 loaded in manual mode.
//      -> saida=all ones, valido=0. Then switch to scan -> canal=0 and valido=1 after 2 edges.
//   6. Reset mid-scan: at canal=2, prescaler=1, assert reset with modo=1 held.
//      -> all outputs return to reset values; the scan restarts from channel 0 with a full PRESCALE period.

Source files
------------

// File: rtl/jogo_pkg.sv
// Constants shared across the Memory Challenge datapath.
package jogo_pkg;

    localparam logic MODO_MANUAL    = 1'b0;
    localparam logic MODO_VARREDURA = 1'b1;

endpackage

// File: rtl/mux_nx1_varredura_if.sv
// Channel-selector bus: packed channel words and controls in, selected word and status out.
interface mux_nx1_varredura_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N*W-1:0]   dados;
    logic [SEL_W-1:0] sel;
    logic             carrega_sel;
    logic             modo;
    logic             habilita;
    logic [W-1:0]     saida;
    logic [SEL_W-1:0] canal;
    logic             valido;
    logic             fim_varredura;

    modport master (
        output dados, sel, carrega_sel, modo, habilita,
        input  saida, canal, valido, fim_varredura
    );

    modport slave (
        input  dados, sel, carrega_sel, modo, habilita,
        output saida, canal, valido, fim_varredura
    );

endinterface

// File: rtl/contador_m.sv
// Modulo-M counter with enable and sync clear; fim flags the wrap cycle (combinational).
module contador_m #(
    parameter int unsigned M = 4,
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic habilita,
    input  logic limpa,
    output logic fim
);

    localparam logic [CW-1:0] ULTIMO = CW'(M - 1);

    logic [CW-1:0] contagem_q, contagem_d;

    always_comb begin
        fim        = habilita && !limpa && (contagem_q == ULTIMO);
        contagem_d = contagem_q;
        if (limpa) begin
            contagem_d = '0;
        end else if (habilita) begin
            contagem_d = fim ? '0 : contagem_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

endmodule

// File: rtl/mux_nx1_varredura.sv
// Registered N-to-1 word selector with manual channel load or prescaled automatic scan.
module mux_nx1_varredura
    import jogo_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 4,
    parameter int unsigned PRESCALE = 50000,
    localparam int unsigned SEL_W   = $clog2(N)
) (
    input logic                  clock,
    input logic                  reset,
    mux_nx1_varredura_if.slave   bus
);

    localparam logic [SEL_W:0]   NUM_CH = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(N - 1);

    logic [SEL_W-1:0] canal_q, canal_d;
    logic [W-1:0]     saida_q, saida_d;
    logic             valido_q, valido_d;
    logic             fim_q, fim_d;
    logic             modo_q;

    logic entra_varredura;
    logic limpa_presc;
    logic habilita_presc;
    logic tick;

    // Entering scan restarts at channel 0 with a fresh prescaler and suppresses the tick.
    assign entra_varredura = (bus.modo == MODO_VARREDURA) && (modo_q == MODO_MANUAL);
    assign limpa_presc     = (bus.modo == MODO_MANUAL) || entra_varredura;
    assign habilita_presc  = (bus.modo == MODO_VARREDURA) && bus.habilita;

    contador_m #(
        .M (PRESCALE)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .habilita (habilita_presc),
        .limpa    (limpa_presc),
        .fim      (tick)
    );

    always_comb begin
        canal_d = canal_q;
        fim_d   = 1'b0;
        if (entra_varredura) begin
            canal_d = '0;
        end else if (bus.modo == MODO_MANUAL) begin
            if (bus.carrega_sel) begin
                canal_d = bus.sel;
            end
        end else if (tick) begin
            // Out-of-range indices also wrap to 0.
            canal_d = (canal_q >= ULTIMO) ? '0 : canal_q + 1'b1;
            fim_d   = (canal_q == ULTIMO);
        end
    end

    always_comb begin
        if ({1'b0, canal_q} < NUM_CH) begin
            saida_d  = bus.dados[canal_q * W +: W];
            valido_d = 1'b1;
        end else begin
            saida_d  = '1;
            valido_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            canal_q  <= '0;
            saida_q  <= '0;
            valido_q <= 1'b0;
            fim_q    <= 1'b0;
            modo_q   <= MODO_MANUAL;
        end else begin
            canal_q  <= canal_d;
            saida_q  <= saida_d;
            valido_q <= valido_d;
            fim_q    <= fim_d;
            modo_q   <= bus.modo;
        end
    end

    assign bus.saida         = saida_q;
    assign bus.canal         = canal_q;
    assign bus.valido        = valido_q;
    assign bus.fim_varredura = fim_q;

endmodule
